custom_ahb_lcd_8080: RTL and testbench

AHB-Lite slave that drives an 8080-style parallel LCD bus in hardware, replacing per-bit software toggling of CS/RS/WR/DATA. Software pushes command and data words into a write FIFO; an internal write-cycle engine generates RS/DATA/WR strobes with programmable low/high widths. It sits on the AHB peripheral bus alongside the other custom slaves and connects directly to the LCD pins.

---
 rtl/custom_ahb_lcd_8080.sv | 181 ++++++++++++++++++
 tb/tb_custom_ahb_lcd_8080.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_ahb_lcd_8080.sv
// AHB-Lite slave that queues LCD command/data words in a FIFO and plays them out
// on an 8080-style parallel bus with programmable WR low/high widths.
module custom_ahb_lcd_8080 #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int T_LO_RST   = 2,
    parameter int T_HI_RST   = 2
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [3:0]        HPROT,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    output logic              HRESP,
    output logic              LCD_CS,
    output logic              LCD_RS,
    output logic              LCD_WR,
    output logic              LCD_RD,
    output logic              LCD_RST,
    output logic              LCD_BL_CTR,
    output logic [DATA_W-1:0] LCD_DATA
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [5:0] OFF_CTRL = 6'h00, OFF_CMD = 6'h01, OFF_DAT = 6'h02,
                           OFF_STAT = 6'h03, OFF_TIM = 6'h04;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WLO, S_WHI} state_e;

    logic              dph_vld_q, dph_wr_q;
    logic [5:0]        dph_off_q;
    logic [2:0]        ctrl_q;
    logic [7:0]        tlo_cfg_q, thi_cfg_q, tlo_q, thi_q, cnt_q, cnt_d;
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     level_q;
    state_e            state_q, state_d;
    logic              rs_q, wr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_dph, rd_dph, push_req, push, pop, flush, full, empty, busy;
    logic [8:0]        lvl_ext;

    // Address phase is only accepted when the bus is ready; a stalled push holds it.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dph_vld_q <= 1'b0;
            dph_wr_q  <= 1'b0;
            dph_off_q <= '0;
        end else if (HREADY) begin
            dph_vld_q <= HSEL & HTRANS[1];
            dph_wr_q  <= HWRITE;
            dph_off_q <= HADDR[7:2];
        end
    end

    assign wr_dph    = dph_vld_q & dph_wr_q;
    assign rd_dph    = dph_vld_q & ~dph_wr_q;
    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign empty     = (level_q == '0);
    assign push_req  = wr_dph & ((dph_off_q == OFF_CMD) | (dph_off_q == OFF_DAT));
    assign push      = push_req & ~full;
    assign flush     = wr_dph & (dph_off_q == OFF_CTRL) & HWDATA[3];
    assign busy      = (state_q != S_IDLE) | ~empty;
    assign HREADYOUT = ~(push_req & full);
    assign HRESP     = 1'b0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_q    <= 3'b001;
            tlo_cfg_q <= 8'(T_LO_RST);
            thi_cfg_q <= 8'(T_HI_RST);
        end else if (wr_dph) begin
            if (dph_off_q == OFF_CTRL) ctrl_q <= HWDATA[2:0];
            if (dph_off_q == OFF_TIM) begin
                tlo_cfg_q <= HWDATA[7:0];
                thi_cfg_q <= HWDATA[15:8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) mem_q[wptr_q] <= {(dph_off_q == OFF_DAT), HWDATA[DATA_W-1:0]};
    end

    // Flush overrides any pop in the same cycle; the popped word still goes out.
    always_ff @(posedge HCLK) begin
        if (HRESET || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                state_d = S_WLO;
                cnt_d   = tlo_q - 8'd1;
            end
            S_WLO: if (cnt_q == 8'd0) begin
                state_d = S_WHI;
                cnt_d   = thi_q - 8'd1;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            S_WHI: if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else if (!empty) begin
                pop     = 1'b1;
                state_d = S_SETUP;
            end else begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tlo_q   <= 8'd1;
            thi_q   <= 8'd1;
            rs_q    <= 1'b0;
            data_q  <= '0;
            wr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= (state_d != S_WLO);
            if (pop) begin
                {rs_q, data_q} <= mem_q[rptr_q];
                tlo_q <= (tlo_cfg_q == 8'd0) ? 8'd1 : tlo_cfg_q;
                thi_q <= (thi_cfg_q == 8'd0) ? 8'd1 : thi_cfg_q;
            end
        end
    end

    assign lvl_ext = 9'(level_q);

    always_comb begin
        HRDATA = '0;
        if (rd_dph) begin
            case (dph_off_q)
                OFF_CTRL: HRDATA[2:0]  = ctrl_q;
                OFF_STAT: HRDATA[15:0] = {lvl_ext[7:0], 5'b0, empty, full, busy};
                OFF_TIM:  HRDATA[15:0] = {thi_cfg_q, tlo_cfg_q};
                default:  HRDATA = '0;
            endcase
        end
    end

    assign LCD_CS     = ctrl_q[0];
    assign LCD_RST    = ctrl_q[1];
    assign LCD_BL_CTR = ctrl_q[2];
    assign LCD_RD     = 1'b1;
    assign LCD_RS     = rs_q;
    assign LCD_WR     = wr_q;
    assign LCD_DATA   = data_q;

    logic unused;
    assign unused = ^{HSIZE, HPROT, HADDR[31:8], HADDR[1:0], HTRANS[0], HWDATA[31:16], lvl_ext[8]};
endmodule

// File: tb/tb_custom_ahb_lcd_8080.sv
// Directed bench for custom_ahb_lcd_8080: bus register access, WR strobe timing,
// FIFO backpressure, flush and reset behaviour against hand-computed values.
module tb_custom_ahb_lcd_8080;
    localparam int DW = 16;
    localparam int FD = 16;

    logic          HCLK = 1'b0;
    logic          HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0]   HADDR, HWDATA, HRDATA;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [3:0]    HPROT;
    logic          LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_BL_CTR;
    logic [DW-1:0] LCD_DATA;

    custom_ahb_lcd_8080 #(.DATA_W(DW), .FIFO_DEPTH(FD), .T_LO_RST(2), .T_HI_RST(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
        .LCD_RST(LCD_RST), .LCD_BL_CTR(LCD_BL_CTR), .LCD_DATA(LCD_DATA));

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    int checks = 0, failures = 0, cyc = 0;
    int fall_c[$], rise_c[$];
    logic [DW-1:0] dat_m[$];
    logic rs_m[$];
    logic prev_wr = 1'b1;
    bit wr_stalled;
    int wr_cyc;

    always @(posedge HCLK) cyc <= cyc + 1;

    // WR edge monitor: log the cycle of every edge plus the bus value at each fall.
    always @(negedge HCLK) begin
        if (prev_wr === 1'b1 && LCD_WR === 1'b0) begin
            fall_c.push_back(cyc);
            dat_m.push_back(LCD_DATA);
            rs_m.push_back(LCD_RS);
        end
        if (prev_wr === 1'b0 && LCD_WR === 1'b1) rise_c.push_back(cyc);
        prev_wr = LCD_WR;
    end

    task automatic clear_mon();
        fall_c.delete(); rise_c.delete(); dat_m.delete(); rs_m.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [5:0] off, input logic [31:0] d);
        int n;
        n = 0;
        wr_stalled = 0;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {24'h0, off, 2'b00};
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
        @(negedge HCLK);
        while (HREADYOUT !== 1'b1 && n < 1000) begin
            wr_stalled = 1; n++;
            @(negedge HCLK);
        end
        if (n >= 1000) begin
            checks++; failures++;
            $display("FAIL write_timeout off=%h HREADYOUT stuck at %b, required 1", off, HREADYOUT);
        end
        @(posedge HCLK); #1;
        wr_cyc = cyc;
    endtask

    task automatic ahb_read(input logic [5:0] off, output logic [31:0] d);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = {24'h0, off, 2'b00};
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        @(negedge HCLK);
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic check_reset_pins(input string tag);
        logic [31:0] r;
        @(negedge HCLK);
        checks++;
        if ({LCD_CS, LCD_RST, LCD_BL_CTR, LCD_RS, LCD_WR, LCD_RD, HREADYOUT, HRESP} !== 8'b1000_1110) begin
            failures++;
            $display("FAIL %s_pins got=%b required=10001110", tag,
                     {LCD_CS, LCD_RST, LCD_BL_CTR, LCD_RS, LCD_WR, LCD_RD, HREADYOUT, HRESP});
        end
        checks++;
        if (LCD_DATA !== '0 || HRDATA !== 32'h0) begin
            failures++;
            $display("FAIL %s_data got data=%h hrdata=%h required 0/0", tag, LCD_DATA, HRDATA);
        end
        @(posedge HCLK); #1;
        ahb_read(6'h03, r);
        checks++;
        if (r !== 32'h4) begin failures++; $display("FAIL %s_status got=%h required=00000004", tag, r); end
        ahb_read(6'h04, r);
        checks++;
        if (r !== 32'h0202) begin failures++; $display("FAIL %s_timing got=%h required=00000202", tag, r); end
        ahb_read(6'h00, r);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL %s_ctrl got=%h required=00000001", tag, r); end
    endtask

    task automatic test_reset();
        HRESET = 1;
        wait_cyc(3);
        HRESET = 0;
        check_reset_pins("reset");
    endtask

    task automatic test_single();
        logic [31:0] r;
        int push_c;
        clear_mon();
        ahb_write(6'h02, 32'h0000_A5A5);
        push_c = wr_cyc;
        ahb_read(6'h03, r);
        checks++;
        if (r !== 32'h5) begin failures++; $display("FAIL single_busy got=%h required=00000005", r); end
        wait_cyc(3);
        ahb_read(6'h03, r);
        checks++;
        if (r !== 32'h4) begin failures++; $display("FAIL single_idle got=%h required=00000004", r); end
        checks++;
        if (fall_c.size() != 1 || rise_c.size() != 1) begin
            failures++;
            $display("FAIL single_pulses got falls=%0d rises=%0d required 1/1", fall_c.size(), rise_c.size());
        end else begin
            checks++;
            if (fall_c[0] - push_c != 2) begin
                failures++; $display("FAIL single_latency got=%0d required=2", fall_c[0] - push_c);
            end
            checks++;
            if (rise_c[0] - fall_c[0] != 2) begin
                failures++; $display("FAIL single_wr_low got=%0d required=2", rise_c[0] - fall_c[0]);
            end
            checks++;
            if (dat_m[0] !== 16'hA5A5 || rs_m[0] !== 1'b1) begin
                failures++; $display("FAIL single_bus got data=%h rs=%b required A5A5/1", dat_m[0], rs_m[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        ahb_write(6'h04, 32'h0000_0301);
        clear_mon();
        ahb_write(6'h01, 32'h0000_0011);
        ahb_write(6'h02, 32'h0000_0022);
        wait_cyc(15);
        checks++;
        if (fall_c.size() != 2 || rise_c.size() != 2) begin
            failures++;
            $display("FAIL b2b_pulses got falls=%0d rises=%0d required 2/2", fall_c.size(), rise_c.size());
        end else begin
            checks++;
            if (rs_m[0] !== 1'b0 || dat_m[0] !== 16'h0011 || rs_m[1] !== 1'b1 || dat_m[1] !== 16'h0022) begin
                failures++;
                $display("FAIL b2b_bus got %b/%h %b/%h required 0/0011 1/0022", rs_m[0], dat_m[0], rs_m[1], dat_m[1]);
            end
            checks++;
            if (rise_c[0] - fall_c[0] != 1 || rise_c[1] - fall_c[1] != 1) begin
                failures++;
                $display("FAIL b2b_wr_low got %0d,%0d required 1,1", rise_c[0] - fall_c[0], rise_c[1] - fall_c[1]);
            end
            checks++;
            if (fall_c[1] - rise_c[0] != 4) begin
                failures++; $display("FAIL b2b_wr_high got=%0d required=4", fall_c[1] - rise_c[0]);
            end
            checks++;
            if (fall_c[1] - fall_c[0] != 5) begin
                failures++; $display("FAIL b2b_period got=%0d required=5", fall_c[1] - fall_c[0]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [17:0] mask;
        logic [31:0] r;
        int n;
        ahb_write(6'h04, 32'h0000_1414);
        clear_mon();
        mask = '0;
        for (int i = 0; i < FD + 2; i++) begin
            ahb_write(6'h02, 32'h1000 + i);
            mask[i] = wr_stalled;
        end
        checks++;
        if (mask !== 18'h20000) begin failures++; $display("FAIL ovf_stall_mask got=%h required=20000", mask); end
        n = 0;
        while (fall_c.size() < FD + 2 && n < 2000) begin @(posedge HCLK); n++; end
        #1;
        wait_cyc(50);
        checks++;
        if (fall_c.size() != FD + 2) begin
            failures++; $display("FAIL ovf_count got=%0d required=%0d", fall_c.size(), FD + 2);
        end
        for (int i = 0; i < FD + 2 && i < fall_c.size(); i++) begin
            checks++;
            if (dat_m[i] !== 16'(16'h1000 + i) || rs_m[i] !== 1'b1) begin
                failures++;
                $display("FAIL ovf_word%0d got=%h rs=%b required=%h rs=1", i, dat_m[i], rs_m[i], 16'(16'h1000 + i));
            end
        end
        ahb_read(6'h03, r);
        checks++;
        if (r !== 32'h4) begin failures++; $display("FAIL ovf_status got=%h required=00000004", r); end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        clear_mon();
        for (int i = 0; i < 11; i++) ahb_write(6'h02, 32'h2000 + i);
        ahb_write(6'h00, 32'h0000_0009);
        ahb_read(6'h03, r);
        checks++;
        if (r !== 32'h5) begin failures++; $display("FAIL flush_level got=%h required=00000005", r); end
        wait_cyc(60);
        ahb_read(6'h03, r);
        checks++;
        if (r !== 32'h4) begin failures++; $display("FAIL flush_idle got=%h required=00000004", r); end
        checks++;
        if (fall_c.size() != 1 || rise_c.size() != 1) begin
            failures++;
            $display("FAIL flush_pulses got falls=%0d rises=%0d required 1/1", fall_c.size(), rise_c.size());
        end else begin
            checks++;
            if (rise_c[0] - fall_c[0] != 20 || dat_m[0] !== 16'h2000) begin
                failures++;
                $display("FAIL flush_pulse got low=%0d data=%h required 20/2000", rise_c[0] - fall_c[0], dat_m[0]);
            end
        end
    endtask

    task automatic test_ctrl();
        logic [31:0] r;
        ahb_write(6'h00, 32'h0000_0007);
        @(negedge HCLK);
        checks++;
        if ({LCD_CS, LCD_RST, LCD_BL_CTR} !== 3'b111) begin
            failures++; $display("FAIL ctrl_pins got=%b required=111", {LCD_CS, LCD_RST, LCD_BL_CTR});
        end
        @(posedge HCLK); #1;
        ahb_read(6'h00, r);
        checks++;
        if (r !== 32'h7) begin failures++; $display("FAIL ctrl_read got=%h required=00000007", r); end
        ahb_read(6'h3F, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h required=00000000", r); end
        ahb_write(6'h3F, 32'hFFFF_FFFF);
        ahb_read(6'h01, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL cmd_read got=%h required=00000000", r); end
        ahb_read(6'h04, r);
        checks++;
        if (r !== 32'h1414) begin failures++; $display("FAIL unmapped_write_timing got=%h required=00001414", r); end
        ahb_write(6'h00, 32'h0000_0002);
        @(negedge HCLK);
        checks++;
        if ({LCD_CS, LCD_RST, LCD_BL_CTR} !== 3'b010) begin
            failures++; $display("FAIL ctrl_pins2 got=%b required=010", {LCD_CS, LCD_RST, LCD_BL_CTR});
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) ahb_write(6'h02, 32'h00AA + i);
        wait_cyc(3);
        @(negedge HCLK);
        checks++;
        if (LCD_WR !== 1'b0) begin failures++; $display("FAIL midrst_pre_wr got=%b required=0", LCD_WR); end
        @(posedge HCLK); #1;
        HRESET = 1;
        wait_cyc(3);
        HRESET = 0;
        clear_mon();
        check_reset_pins("midrst");
        wait_cyc(30);
        checks++;
        if (fall_c.size() != 0 || LCD_WR !== 1'b1) begin
            failures++; $display("FAIL midrst_no_pulse got falls=%0d wr=%b required 0/1", fall_c.size(), LCD_WR);
        end
    endtask

    initial begin
        HRESET = 1; HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = '0; HWDATA = '0;
        HSIZE = 3'b010; HPROT = 4'b0011;
        @(posedge HCLK); #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_ctrl();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
